// File: rtl/cfg_chain_loader_pkg.sv
// Shared types and size helpers for the configuration chain loader.
// State set grows a CSUM state when CFG_CHAIN_LOADER_CSUM_EN is defined.
package cfg_chain_loader_pkg;

`ifdef CFG_CHAIN_LOADER_CSUM_EN
    typedef enum logic [2:0] {StIdle, StFetch, StShift, StCsum, StCommit} state_e;
`else
    typedef enum logic [1:0] {StIdle, StFetch, StShift, StCommit} state_e;
`endif

    function automatic int unsigned calc_num_words(input int unsigned word_w,
                                                   input int unsigned chain_len);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    function automatic int unsigned calc_last_bits(input int unsigned word_w,
                                                   input int unsigned chain_len);
        return chain_len - (calc_num_words(word_w, chain_len) - 1) * word_w;
    endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Holds one configuration word and walks it out LSB-first, flagging the
// final bit for the caller-supplied bit limit.
module cfg_word_serializer
    import cfg_chain_loader_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [WORD_W-1:0]            data,
    input  logic                         advance,
    input  logic [$clog2(WORD_W+1)-1:0]  bit_limit,
    output logic                         shift_bit,
    output logic                         last_bit
);

    localparam int unsigned IdxW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned LimW = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] word_q, word_d;
    logic [IdxW-1:0]   idx_q, idx_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (load) begin
            word_d = data;
            idx_d  = '0;
        end else if (advance && !last_bit) begin
            // Hold at the limit so the index never wraps.
            idx_d = idx_q + IdxW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign shift_bit = word_q[idx_q];
    assign last_bit  = (LimW'(idx_q) == (bit_limit - LimW'(1)));

endmodule

// File: rtl/cfg_chain_loader.sv
// Feeds the CLB switch-box configuration chain from a valid/ready word stream and
// pulses set_out once CHAIN_LEN bits are in. CFG_CHAIN_LOADER_CSUM_EN adds an XOR checksum word.
module cfg_chain_loader
    import cfg_chain_loader_pkg::*;
#(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned CHAIN_LEN = 72
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              cen,
    output logic              shift_in,
    output logic              set_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned NUM_WORDS = calc_num_words(WORD_W, CHAIN_LEN);
    localparam int unsigned LAST_BITS = calc_last_bits(WORD_W, CHAIN_LEN);
    localparam int unsigned WcW       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned LimW      = $clog2(WORD_W + 1);

    state_e           state_q, state_d;
    logic [WcW-1:0]   word_cnt_q, word_cnt_d;
    logic             ser_load, ser_advance, ser_bit, ser_last;
    logic             is_final;
    logic [LimW-1:0]  bit_limit;

`ifdef CFG_CHAIN_LOADER_CSUM_EN
    localparam logic [WORD_W-1:0] LastMask = {WORD_W{1'b1}} >> (WORD_W - LAST_BITS);
    logic [WORD_W-1:0] acc_q, acc_d;
    logic              err_q, err_d;
`endif

    assign is_final  = (word_cnt_q == WcW'(NUM_WORDS - 1));
    assign bit_limit = is_final ? LimW'(LAST_BITS) : LimW'(WORD_W);

    cfg_word_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .data      (s_data),
        .advance   (ser_advance),
        .bit_limit (bit_limit),
        .shift_bit (ser_bit),
        .last_bit  (ser_last)
    );

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        ser_load    = 1'b0;
        ser_advance = 1'b0;
`ifdef CFG_CHAIN_LOADER_CSUM_EN
        acc_d       = acc_q;
        err_d       = 1'b0;
`endif
        // Abort beats everything, including a same-cycle start in idle.
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d    = StFetch;
                        word_cnt_d = '0;
`ifdef CFG_CHAIN_LOADER_CSUM_EN
                        acc_d      = '0;
`endif
                    end
                end
                StFetch: begin
                    if (s_valid) begin
                        ser_load = 1'b1;
                        state_d  = StShift;
`ifdef CFG_CHAIN_LOADER_CSUM_EN
                        acc_d    = acc_q ^ (is_final ? (s_data & LastMask) : s_data);
`endif
                    end
                end
                StShift: begin
                    ser_advance = 1'b1;
                    if (ser_last) begin
                        if (is_final) begin
`ifdef CFG_CHAIN_LOADER_CSUM_EN
                            state_d = StCsum;
`else
                            state_d = StCommit;
`endif
                        end else begin
                            word_cnt_d = word_cnt_q + WcW'(1);
                            state_d    = StFetch;
                        end
                    end
                end
`ifdef CFG_CHAIN_LOADER_CSUM_EN
                StCsum: begin
                    if (s_valid) begin
                        if (s_data == acc_q) begin
                            state_d = StCommit;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
`endif
                StCommit: state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
        end
    end

`ifdef CFG_CHAIN_LOADER_CSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            err_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            err_q <= err_d;
        end
    end

    assign err     = err_q;
    assign s_ready = (state_q == StFetch) || (state_q == StCsum);
`else
    assign err     = 1'b0;
    assign s_ready = (state_q == StFetch);
`endif

    assign cen      = (state_q == StShift);
    assign shift_in = cen & ser_bit;
    assign set_out  = (state_q == StCommit);
    assign done     = (state_q == StCommit);
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader at default parameters (32-bit words, 72-bit chain).
// Define CFG_CHAIN_LOADER_CSUM_EN to exercise the checksum word.
module tb_cfg_chain_loader;

`ifdef CFG_CHAIN_LOADER_CSUM_EN
    localparam int CsumExtra = 1;
    localparam int NFeed     = 4;
`else
    localparam int CsumExtra = 0;
    localparam int NFeed     = 3;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        cen;
    logic        shift_in;
    logic        set_out;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wv [4];

    cfg_chain_loader #(
        .WORD_W    (32),
        .CHAIN_LEN (72)
    ) dut (
        .clk      (clk),
        .rst      (rst_n),
        .start    (start),
        .abort    (abort),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .cen      (cen),
        .shift_in (shift_in),
        .set_out  (set_out),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_bit(input int k);
        logic [31:0] w;
        w = wv[k / 32];
        return w[k % 32];
    endfunction

    // Load words wv[0..2] (plus checksum word when enabled) and check the stream.
    task automatic run_load(input string name, input int stall, input bit poke_start,
                            input bit bad_csum);
        int cyc, fed, cen_cnt, stall_left, bit_err, nruns, run, gap;
        int sets, errs, pulse_cyc, last_cen, done_bad;
        int runs [8];
        int gaps [8];
        bit fin;
        cyc = 0; fed = 0; cen_cnt = 0; stall_left = stall; bit_err = 0; nruns = 0;
        run = 0; gap = 0; sets = 0; errs = 0; pulse_cyc = -1; last_cen = -1;
        done_bad = 0; fin = 1'b0;
        for (int i = 0; i < 8; i++) begin
            runs[i] = 0;
            gaps[i] = 0;
        end
        wv[3] = wv[0] ^ wv[1] ^ (wv[2] & 32'h0000_00FF) ^ {31'd0, bad_csum};

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!fin && cyc < 400) begin
            cyc++;
            if (cen) begin
                if (run == 0) begin
                    if (nruns < 8) gaps[nruns] = gap;
                    gap = 0;
                end
                if (cen_cnt < 72 && shift_in !== exp_bit(cen_cnt)) bit_err++;
                cen_cnt++;
                run++;
                last_cen = cyc;
            end else begin
                if (run > 0) begin
                    if (nruns < 8) runs[nruns] = run;
                    nruns++;
                    run = 0;
                end
                gap++;
            end
            if (done !== set_out) done_bad++;
            if (set_out) begin sets++; pulse_cyc = cyc; fin = 1'b1; end
            if (err) begin errs++; pulse_cyc = cyc; fin = 1'b1; end

            s_valid = 1'b0;
            if (s_ready && fed < NFeed) begin
                if (fed == 1 && stall_left > 0) begin
                    stall_left--;
                end else begin
                    s_valid = 1'b1;
                    s_data  = wv[fed];
                    fed++;
                end
            end
            start = poke_start && (cen_cnt == 10);
            @(posedge clk); #1;
        end
        start   = 1'b0;
        s_valid = 1'b0;

        checks++;
        if (fin !== 1'b1) begin
            failures++;
            $display("FAIL %s timeout: got no pulse within %0d cycles, required a pulse", name, cyc);
        end
        checks++;
        if (bit_err !== 0) begin
            failures++;
            $display("FAIL %s bits: %0d wrong shift_in bits, required 0", name, bit_err);
        end
        checks++;
        if (cen_cnt !== 72) begin
            failures++;
            $display("FAIL %s cen_count: got %0d, required 72", name, cen_cnt);
        end
        checks++;
        if (nruns !== 3 || runs[0] !== 32 || runs[1] !== 32 || runs[2] !== 8) begin
            failures++;
            $display("FAIL %s runs: got n=%0d %0d/%0d/%0d, required n=3 32/32/8", name, nruns,
                     runs[0], runs[1], runs[2]);
        end
        checks++;
        if (gaps[0] !== 1 || gaps[1] !== 1 + stall || gaps[2] !== 1) begin
            failures++;
            $display("FAIL %s gaps: got %0d/%0d/%0d, required 1/%0d/1", name, gaps[0], gaps[1],
                     gaps[2], 1 + stall);
        end
        checks++;
        if (bad_csum ? (errs !== 1 || sets !== 0) : (sets !== 1 || errs !== 0)) begin
            failures++;
            $display("FAIL %s outcome: got set=%0d err=%0d, required set=%0d err=%0d", name, sets,
                     errs, bad_csum ? 0 : 1, bad_csum ? 1 : 0);
        end
        checks++;
        if (pulse_cyc !== last_cen + 1 + CsumExtra) begin
            failures++;
            $display("FAIL %s pulse_after_shift: got cycle %0d, required %0d", name, pulse_cyc,
                     last_cen + 1 + CsumExtra);
        end
        checks++;
        if (pulse_cyc !== 76 + stall + CsumExtra) begin
            failures++;
            $display("FAIL %s load_length: got %0d cycles, required %0d", name, pulse_cyc,
                     76 + stall + CsumExtra);
        end
        checks++;
        if (done_bad !== 0) begin
            failures++;
            $display("FAIL %s done_vs_set: %0d cycles differ, required 0", name, done_bad);
        end
        checks++;
        if ({set_out, done, busy, err, cen} !== 5'b0) begin
            failures++;
            $display("FAIL %s after_pulse: got set/done/busy/err/cen=%b, required 00000", name,
                     {set_out, done, busy, err, cen});
        end
    endtask

    task automatic test_reset();
        start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        rst_n = 1'b0;
        #3;
        checks++;
        if ({s_ready, cen, shift_in, set_out, busy, done, err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b, required 0000000",
                     {s_ready, cen, shift_in, set_out, busy, done, err});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({s_ready, cen, busy} !== 3'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got ready/cen/busy=%b, required 000",
                     {s_ready, cen, busy});
        end
    endtask

    task automatic test_no_stall();
        wv[0] = 32'h0000_0001; wv[1] = 32'h8000_0000; wv[2] = 32'hFFFF_FFA5;
        run_load("no_stall", 0, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        wv[0] = 32'h0000_0001; wv[1] = 32'h8000_0000; wv[2] = 32'hFFFF_FFA5;
        run_load("stall", 5, 1'b0, 1'b0);
    endtask

    task automatic test_start_in_shift();
        wv[0] = 32'hDEAD_BEEF; wv[1] = 32'h0123_4567; wv[2] = 32'h0000_003C;
        run_load("start_in_shift", 0, 1'b1, 1'b0);
    endtask

    task automatic test_abort();
        int cyc, fed, cen_cnt, sets;
        wv[0] = 32'h0000_0001; wv[1] = 32'h8000_0000; wv[2] = 32'hFFFF_FFA5;
        cyc = 0; fed = 0; cen_cnt = 0; sets = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (cen_cnt < 40 && cyc < 200) begin
            cyc++;
            if (cen) cen_cnt++;
            if (set_out) sets++;
            s_valid = 1'b0;
            if (s_ready && fed < 3) begin
                s_valid = 1'b1;
                s_data  = wv[fed];
                fed++;
            end
            if (cen_cnt == 40) abort = 1'b1;
            @(posedge clk); #1;
        end
        abort   = 1'b0;
        s_valid = 1'b0;
        checks++;
        if (cen_cnt !== 40) begin
            failures++;
            $display("FAIL abort_reach40: got %0d shifted bits, required 40", cen_cnt);
        end
        checks++;
        if ({busy, cen} !== 2'b00) begin
            failures++;
            $display("FAIL abort_idle: got busy/cen=%b, required 00", {busy, cen});
        end
        repeat (10) begin
            if (set_out || done) sets++;
            @(posedge clk); #1;
        end
        checks++;
        if (sets !== 0) begin
            failures++;
            $display("FAIL abort_no_set: got %0d set pulses, required 0", sets);
        end
        run_load("after_abort", 0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        int cyc, fed, cen_cnt, bad;
        wv[0] = 32'hA5A5_5A5A; wv[1] = 32'hFFFF_FFFF; wv[2] = 32'h0000_00FF;
        cyc = 0; fed = 0; cen_cnt = 0; bad = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (cen_cnt < 10 && cyc < 200) begin
            cyc++;
            if (cen) cen_cnt++;
            s_valid = 1'b0;
            if (s_ready && fed < 3) begin
                s_valid = 1'b1;
                s_data  = wv[fed];
                fed++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (cen !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_shift: got cen=%b, required 1", cen);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, cen, shift_in, set_out, busy, done, err} !== 7'b0) begin
            failures++;
            $display("FAIL async_reset_outputs: got %b, required 0000000",
                     {s_ready, cen, shift_in, set_out, busy, done, err});
        end
        @(negedge clk);
        rst_n   = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'hFFFF_FFFF;
        repeat (30) begin
            @(posedge clk); #1;
            if (set_out || done || busy || cen) bad++;
        end
        s_valid = 1'b0;
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL post_reset_quiet: got %0d active cycles, required 0", bad);
        end
    endtask

    task automatic test_start_abort_idle();
        int bad;
        bad   = 0;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) begin
            if (busy || s_ready || cen) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL start_abort_idle: got %0d busy cycles, required 0", bad);
        end
    endtask

    task automatic test_csum();
        wv[0] = 32'h1234_5678; wv[1] = 32'h0F0F_0F0F; wv[2] = 32'h0000_01FF;
        run_load("csum_good", 0, 1'b0, 1'b0);
`ifdef CFG_CHAIN_LOADER_CSUM_EN
        checks++;
        if (wv[3] !== 32'h1D3B_5988) begin
            failures++;
            $display("FAIL csum_model: got %h, required 1d3b5988", wv[3]);
        end
        wv[0] = 32'h1234_5678; wv[1] = 32'h0F0F_0F0F; wv[2] = 32'h0000_01FF;
        run_load("csum_bad", 0, 1'b0, 1'b1);
`endif
    endtask

    initial begin
        test_reset();
        test_no_stall();
        test_stall();
        test_start_in_shift();
        test_abort();
        test_async_reset();
        test_start_abort_idle();
        test_csum();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
Upstream feeder for the baked CLB switch-box configuration chain. Accepts configuration words from the fabric programming interface over a valid/ready stream. Serializes them LSB-first onto the tile shift chain, driving `cen` and `shift_in`. After exactly CHAIN_LEN bits have been shifted, it issues a one-cycle `set` pulse that commits the chain into the switch-box registers.

Parameters:
- WORD_W, 32, width of one incoming configuration word.
- CHAIN_LEN, 72, total chain bits; the default equals (WS + WD/2)*6 with WS=8, WD=8.
- NUM_WORDS, ceil(CHAIN_LEN/WORD_W), derived (localparam); 3 at defaults.
- LAST_BITS, CHAIN_LEN - (NUM_WORDS-1)*WORD_W, derived (localparam); 8 at defaults.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  begin a load; sampled only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE with no commit.
- s_valid  input  1  word valid.
- s_ready  output  1  loader can accept a word.
- s_data  input  WORD_W  configuration word.
- cen  output  1  chain shift enable.
- shift_in  output  1  serial bit into the chain.
- set_out  output  1  one-cycle commit pulse to the tile `set_in`.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse, concurrent with `set_out`.
- err  output  1  one-cycle checksum-failure pulse; tied 0 without the optional feature.

Behaviour:
- Reset (rst=0, async): state=IDLE, counters=0; all outputs 0.
- States: IDLE, FETCH, SHIFT, (CSUM), COMMIT.
- IDLE: on `start`=1 go to FETCH next cycle.
- FETCH
  - `s_ready`=1 and `cen`=0.
  - Handshake fires on `s_valid` & `s_ready`; the word is registered and the state moves to SHIFT.
  - Stalls indefinitely while `s_valid`=0.
- SHIFT
  - `cen`=1 every cycle; `shift_in`=word[bit_idx]; bit_idx starts at 0 and increments each cycle.
  - A word ends after WORD_W bits, or after LAST_BITS bits for the final word. Excess upper bits of the final word are ignored.
  - At the end of a non-final word, go to FETCH.
  - At the end of the final word, go to COMMIT, or to CSUM when the feature is enabled.
  - A one-cycle `cen`=0 bubble per word fetch is required. Total `cen`-high cycles per load = CHAIN_LEN exactly.
- COMMIT: `set_out`=1 and `done`=1 for one cycle, then IDLE.
- Chain bit order: the first bit shifted is s_data[0] of word 0, and ends deepest in the chain.
- `start` while `busy` is ignored. `start` and `abort` in the same IDLE cycle: abort wins, stay IDLE.
- `abort` in any non-IDLE state: next cycle IDLE, `cen`=0, no `set_out`/`done`. Partial chain contents are left undefined.
- Reset mid-load: same as `abort`. No `set_out` is ever emitted for a partial load.
- The bit counter never wraps; the word counter counts 0..NUM_WORDS-1.

Optional Feature:
- Macro: CFG_CHAIN_LOADER_CSUM_EN.
- With the macro:
  - After the final data word, CSUM state asserts `s_ready` for one extra word.
  - The loader keeps an XOR accumulator over all data words, with the final word masked to LAST_BITS.
  - Match: go to COMMIT.
  - Mismatch: `err`=1 for one cycle, no `set_out`/`done`, return to IDLE.
  - `abort` in CSUM behaves as elsewhere.
- Without the macro: no CSUM state, no accumulator, `err` constant 0.

Decomposition:
- Package cfg_chain_loader_pkg: state enum, and functions computing NUM_WORDS/LAST_BITS from WORD_W and CHAIN_LEN.
- One natural sub-module: cfg_word_serializer. It holds the word register and bit index, and produces `shift_in` and a `last_bit` flag for a given bit-limit input.
- The FSM, word counter and checksum stay in cfg_chain_loader.

Test Plan:
- Defaults, no stall: `start`, then words 0x0000_0001, 0x8000_0000, 0xFFFF_FFA5 with `s_valid` held high.
  - `cen` high for exactly 72 cycles in runs 32/32/8, separated by one-cycle bubbles.
  - `shift_in` sequence: 1,0×31; 0×31,1; 1,0,1,0,0,1,0,1.
  - `set_out` and `done` pulse once, one cycle after the last shift.
- Stall: `s_valid` low for 5 cycles before word 1.
  - `cen` stays 0 during the stall; bit stream is identical to the no-stall case.
  - Total load = 72 + 3 fetch + 5 stall + commit cycles.
- Abort after 40 shifted bits: no `set_out`; `busy` low the next cycle; a new `start` then loads cleanly.
- Async reset asserted mid-SHIFT: outputs drop to 0 immediately; no `set_out` after release.
- CSUM_EN, words A=0x1234_5678, B=0x0F0F_0F0F, C=0x0000_01FF:
  - Checksum A^B^(C&0xFF) → `set_out`.
  - Checksum off by one bit → `err` pulse, no `set_out`.
- `start` pulsed during SHIFT has no effect; `start` and `abort` together in IDLE → stays IDLE.
